// File: rtl/perceptron_pkg.sv
// Shared types and defaults for the sequential perceptron neuron.
// Holds the FSM state enum, default geometry and the index-width helper.
// Build option PERCEPTRON_SAT_EN (saturating terms/accumulator) is consumed by perceptron_term and perceptron_seq.
package perceptron_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int DW_DEF    = 8;
  localparam int SW_DEF    = 3;
  localparam int ACC_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACT  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Index counter width; a single-input neuron still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/perceptron_term.sv
// Shift-and-reduce of one input/weight pair into an ACC_W-bit term.
// Latency: purely combinational. Backpressure: none, no handshake.
// PERCEPTRON_SAT_EN: saturate to all-ones on overflow; otherwise wrap modulo 2^ACC_W.
module perceptron_term
  import perceptron_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int SW    = SW_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [DW-1:0]    in_dat,
  input  logic [SW-1:0]    w_dat,
  output logic [ACC_W-1:0] term_dat
);

`ifdef PERCEPTRON_SAT_EN
  localparam int FULL_W = ACC_W + (1 << SW) - 1;

  logic [FULL_W-1:0] full_dat;

  // Full-width shift so no set bit is lost before the overflow test.
  assign full_dat = {{(FULL_W-DW){1'b0}}, in_dat} << w_dat;
  assign term_dat = (|full_dat[FULL_W-1:ACC_W]) ? {ACC_W{1'b1}} : full_dat[ACC_W-1:0];
`else
  // Bits shifted past ACC_W are dropped, which equals wrapping modulo 2^ACC_W.
  assign term_dat = {{(ACC_W-DW){1'b0}}, in_dat} << w_dat;
`endif

endmodule

// File: rtl/perceptron_seq.sv
// Sequential perceptron: one shift-weighted term per clock, threshold activation, clamped output.
// Latency: out_valid N_IN+1 cycles after accept; one result per N_IN+3 cycles back-to-back.
// Backpressure: out/out_valid held while out_ready=0; in_ready only in IDLE. PERCEPTRON_SAT_EN selects saturating sums.
module perceptron_seq
  import perceptron_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int DW    = DW_DEF,
  parameter int SW    = SW_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*DW-1:0]   in_vec,
  input  logic [N_IN*SW-1:0]   w_vec,
  input  logic [DW-1:0]        bias,
  input  logic [ACC_W-1:0]     threshold,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out,
  output logic                 busy
);

  localparam int IW = idx_width(N_IN);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_IN - 1);

  state_t state, state_nxt;

  logic [N_IN*DW-1:0] in_q;
  logic [N_IN*SW-1:0] w_q;
  logic [ACC_W-1:0]   thr_q;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [IW-1:0]      idx;
  logic [DW-1:0]      in_sel_dat;
  logic [SW-1:0]      w_sel_dat;
  logic [ACC_W-1:0]   term_dat;
  logic [DW-1:0]      act_dat;

  assign in_sel_dat = in_q[int'(idx)*DW +: DW];
  assign w_sel_dat  = w_q[int'(idx)*SW +: SW];

  perceptron_term #(
    .DW    (DW),
    .SW    (SW),
    .ACC_W (ACC_W)
  ) u_term (
    .in_dat   (in_sel_dat),
    .w_dat    (w_sel_dat),
    .term_dat (term_dat)
  );

`ifdef PERCEPTRON_SAT_EN
  logic [ACC_W:0] sum_dat;

  // One extra carry bit detects overflow; clamp instead of wrapping.
  assign sum_dat = {1'b0, acc} + {1'b0, term_dat};
  assign acc_nxt = sum_dat[ACC_W] ? {ACC_W{1'b1}} : sum_dat[ACC_W-1:0];
`else
  assign acc_nxt = acc + term_dat;
`endif

  // Threshold activation followed by clamp to the DW-bit output range.
  always_comb begin
    act_dat = '0;
    if (acc >= thr_q) begin
      act_dat = (|acc[ACC_W-1:DW]) ? {DW{1'b1}} : acc[DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ACC;
      end
      ACC: begin
        busy = 1'b1;
        if (idx == IDX_LAST) state_nxt = ACT;
      end
      ACT: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q      <= '0;
      w_q       <= '0;
      thr_q     <= '0;
      acc       <= '0;
      idx       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_q  <= in_vec;
            w_q   <= w_vec;
            thr_q <= threshold;
            acc   <= {{(ACC_W-DW){1'b0}}, bias};
            idx   <= '0;
          end
        end
        ACC: begin
          acc <= acc_nxt;
          idx <= idx + IW'(1);
        end
        ACT: begin
          out       <= act_dat;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_seq.sv
// Scoreboard bench for perceptron_seq: driver pushes hand-computed results, monitor pops on each output.
// Expected saturation results follow PERCEPTRON_SAT_EN.
module tb_perceptron_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vec;
  logic [11:0] w_vec;
  logic [7:0]  bias;
  logic [15:0] threshold;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  int         acc_q[$];

  perceptron_seq #(
    .N_IN  (4),
    .DW    (8),
    .SW    (3),
    .ACC_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .w_vec     (w_vec),
    .bias      (bias),
    .threshold (threshold),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] iv, input logic [11:0] wv, input logic [7:0] b,
                      input logic [15:0] th, input logic [7:0] e, input bit hold,
                      output int acc_cyc);
    int n;
    in_valid  = 1'b1;
    in_vec    = iv;
    w_vec     = wv;
    bias      = b;
    threshold = th;
    n = 0;
    acc_cyc = -1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        fail("accept_timeout");
        in_valid = 1'b0;
        return;
      end
    end
    acc_cyc = cyc + 1;
    exp_q.push_back(e);
    acc_q.push_back(acc_cyc);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on each new result, value every cycle valid is high.
  initial begin : monitor
    bit prev_vld;
    int a;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && !prev_vld) begin
          if (acc_q.size() == 0) fail("unexpected_out_valid");
          else begin
            a = acc_q.pop_front();
            check("latency", cyc - a, 5);
          end
        end
        if (out_valid) begin
          if (exp_q.size() == 0) fail("spurious_result");
          else begin
            check(out_ready ? "result" : "hold_value", {24'd0, out}, {24'd0, exp_q[0]});
            check("in_ready_while_valid", {31'd0, in_ready}, 0);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
      prev_vld = out_valid;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] IV_BASIC = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [11:0] WV_BASIC = {3'd3, 3'd2, 3'd1, 3'd0};

  typedef struct {
    logic [31:0] iv;
    logic [11:0] wv;
    logic [7:0]  b;
    logic [15:0] th;
    logic [7:0]  e;
  } vec_t;

  initial begin : driver
    int a, prev_a, n;
    vec_t b2b[6];
    logic [7:0] sat_exp;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_vec    = '0;
    w_vec     = '0;
    bias      = '0;
    threshold = '0;

    #3;
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_out", {24'd0, out}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic sum: 1 + 4 + 12 + 32 + 5 = 54.
    out_ready = 1'b1;
    send(IV_BASIC, WV_BASIC, 8'd5, 16'd10, 8'd54, 1'b0, a);
    check("busy_in_acc", {31'd0, busy}, 1);
    check("in_ready_in_acc", {31'd0, in_ready}, 0);
    drain();

    // Below threshold: 54 < 60.
    send(IV_BASIC, WV_BASIC, 8'd5, 16'd60, 8'd0, 1'b0, a);
    drain();

    // 4 x (255 << 7) = 130560: saturates to 65535, or wraps to 65024 (< 65100).
`ifdef PERCEPTRON_SAT_EN
    sat_exp = 8'd255;
`else
    sat_exp = 8'd0;
`endif
    send(32'hFFFF_FFFF, 12'hFFF, 8'd0, 16'd65100, sat_exp, 1'b0, a);
    drain();

    // Backpressure with an ignored second request.
    out_ready = 1'b0;
    send(IV_BASIC, WV_BASIC, 8'd5, 16'd10, 8'd54, 1'b0, a);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("bp_out_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        in_valid = 1'b1;
        in_vec   = {8'd9, 8'd9, 8'd9, 8'd9};
        @(negedge clk);
        check("bp_in_ready", {31'd0, in_ready}, 0);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_after", {31'd0, in_ready}, 1);
    check("bp_out_valid_after", {31'd0, out_valid}, 0);
    repeat (10) @(posedge clk);
    #1;
    check("bp_busy_idle", {31'd0, busy}, 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset two cycles into accumulation.
    send(IV_BASIC, WV_BASIC, 8'd5, 16'd10, 8'd54, 1'b0, a);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    exp_q.delete();
    acc_q.delete();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_out", {24'd0, out}, 0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(IV_BASIC, WV_BASIC, 8'd5, 16'd10, 8'd54, 1'b0, a);
    drain();

    // Back-to-back with in_valid and out_ready held high.
    b2b[0] = '{{8'd40, 8'd30, 8'd20, 8'd10}, 12'd0, 8'd0, 16'd0, 8'd100};
    b2b[1] = '{{8'd0, 8'd0, 8'd0, 8'd200}, {3'd0, 3'd0, 3'd0, 3'd1}, 8'd100, 16'd0, 8'd255};
    b2b[2] = '{{8'd3, 8'd3, 8'd3, 8'd3}, {3'd1, 3'd1, 3'd1, 3'd1}, 8'd1, 16'd25, 8'd25};
    b2b[3] = '{32'd0, 12'd0, 8'd255, 16'd256, 8'd0};
    b2b[4] = '{32'd0, 12'd0, 8'd255, 16'd255, 8'd255};
    b2b[5] = '{{8'd128, 8'd0, 8'd0, 8'd0}, {3'd1, 3'd0, 3'd0, 3'd0}, 8'd0, 16'd0, 8'd255};
    prev_a = -1;
    for (int i = 0; i < 6; i++) begin
      send(b2b[i].iv, b2b[i].wv, b2b[i].b, b2b[i].th, b2b[i].e, 1'b1, a);
      if (prev_a >= 0) check("b2b_period", a - prev_a, 7);
      prev_a = a;
    end
    in_valid = 1'b0;
    drain();
    repeat (5) @(posedge clk);
    check("final_queue_empty", exp_q.size() + acc_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
